// File: rtl/stream_add_ctrl_if.sv
// AXI4-Lite control bus between the host and the stream-add control block.
// Groups the five AXI-Lite channels (AW, W, B, AR, R) into one bundle.
//   master : host side, drives addresses, write data and response readies.
//   slave  : register block side, drives channel readies and responses.
interface stream_add_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/stream_add_ctrl.sv
// AXI4-Lite control slave and run sequencer for the stream-add kernel.
// Holds the host register map, drives the kernel start handshake, latches the
// element count for each run, counts output data beats and raises interrupt.
// Ports:
//   ap_clk, ap_rst_n         clock, synchronous active-low reset
//   s_axi_control            AXI4-Lite slave (host control port)
//   interrupt                level interrupt to the host
//   k_ap_start               start request to the kernel
//   k_ap_ready/done/idle     kernel status
//   k_n                      element count, stable for the whole run
//   c_TVALID/TREADY/TLAST    passive tap on the kernel output stream
module stream_add_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    stream_add_ctrl_if.slave        s_axi_control,
    output logic                    interrupt,
    output logic                    k_ap_start,
    input  logic                    k_ap_ready,
    input  logic                    k_ap_done,
    input  logic                    k_ap_idle,
    output logic [63:0]             k_n,
    input  logic                    c_TVALID,
    input  logic                    c_TREADY,
    input  logic                    c_TLAST
);
    localparam logic [ADDR_W-1:0] ADDR_CTRL  = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] ADDR_GIE   = ADDR_W'(8'h04);
    localparam logic [ADDR_W-1:0] ADDR_IER   = ADDR_W'(8'h08);
    localparam logic [ADDR_W-1:0] ADDR_ISR   = ADDR_W'(8'h0C);
    localparam logic [ADDR_W-1:0] ADDR_N_LO  = ADDR_W'(8'h10);
    localparam logic [ADDR_W-1:0] ADDR_N_HI  = ADDR_W'(8'h14);
    localparam logic [ADDR_W-1:0] ADDR_BEATS = ADDR_W'(8'h18);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

    // Registers are word-addressed; the byte offset inside a word is ignored.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(3);
    endfunction

    wr_state_t          wr_state, wr_state_nxt;
    rd_state_t          rd_state, rd_state_nxt;
    logic [ADDR_W-1:0]  wr_addr;

    logic               gie;
    logic [1:0]         ier;
    logic [1:0]         isr, isr_nxt;
    logic [31:0]        n_lo, n_hi;
    logic [31:0]        beats;
    logic               auto_restart;
    logic               sts_done, sts_ready, sts_idle;

    logic               aw_hs, w_commit, ar_hs;
    logic [DATA_W-1:0]  wmask;
    logic               wr_ctrl, wr_gie, wr_ier, wr_isr, wr_nlo, wr_nhi;
    logic               start_req, ctrl_rd, beat;
    logic [DATA_W-1:0]  rd_mux;

    // ---------------------------------------------------------------- FSMs
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, regardless of order.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
        end else begin
            wr_state <= wr_state_nxt;
            rd_state <= rd_state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first; a missed branch
    // would otherwise hold its value and infer a latch.
    always_comb begin
        wr_state_nxt          = wr_state;
        s_axi_control.awready = 1'b0;
        s_axi_control.wready  = 1'b0;
        s_axi_control.bvalid  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                s_axi_control.awready = 1'b1;
                if (s_axi_control.awvalid) wr_state_nxt = W_DATA;
            end
            W_DATA: begin
                s_axi_control.wready = 1'b1;
                if (s_axi_control.wvalid) wr_state_nxt = W_RESP;
            end
            W_RESP: begin
                s_axi_control.bvalid = 1'b1;
                if (s_axi_control.bready) wr_state_nxt = W_IDLE;
            end
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_nxt          = rd_state;
        s_axi_control.arready = 1'b0;
        s_axi_control.rvalid  = 1'b0;
        case (rd_state)
            R_IDLE: begin
                s_axi_control.arready = 1'b1;
                if (s_axi_control.arvalid) rd_state_nxt = R_DATA;
            end
            R_DATA: begin
                s_axi_control.rvalid = 1'b1;
                if (s_axi_control.rready) rd_state_nxt = R_IDLE;
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    assign s_axi_control.bresp = 2'b00;
    assign s_axi_control.rresp = 2'b00;

    // ------------------------------------------------------- write decode
    assign aw_hs    = (wr_state == W_IDLE) && s_axi_control.awvalid;
    assign w_commit = (wr_state == W_DATA) && s_axi_control.wvalid;
    assign ar_hs    = (rd_state == R_IDLE) && s_axi_control.arvalid;

    always_comb begin
        wmask = '0;
        for (int b = 0; b < DATA_W / 8; b++) begin
            wmask[b*8 +: 8] = {8{s_axi_control.wstrb[b]}};
        end
    end

    assign wr_ctrl = w_commit && (word_addr(wr_addr) == ADDR_CTRL);
    assign wr_gie  = w_commit && (word_addr(wr_addr) == ADDR_GIE);
    assign wr_ier  = w_commit && (word_addr(wr_addr) == ADDR_IER);
    assign wr_isr  = w_commit && (word_addr(wr_addr) == ADDR_ISR);
    assign wr_nlo  = w_commit && (word_addr(wr_addr) == ADDR_N_LO);
    assign wr_nhi  = w_commit && (word_addr(wr_addr) == ADDR_N_HI);

    // A start write during a run is dropped rather than queued.
    assign start_req = wr_ctrl && s_axi_control.wstrb[0] && s_axi_control.wdata[0] && !k_ap_start;
    assign ctrl_rd   = ar_hs && (word_addr(s_axi_control.araddr) == ADDR_CTRL);
    assign beat      = c_TVALID && c_TREADY && !c_TLAST;

    // Host toggle is applied first, then kernel events OR in, so a
    // simultaneous event is never lost to a host acknowledge.
    always_comb begin
        isr_nxt = isr;
        if (wr_isr && s_axi_control.wstrb[0]) isr_nxt = isr ^ s_axi_control.wdata[1:0];
        isr_nxt = isr_nxt | ({k_ap_ready, k_ap_done} & ier);
    end

    always_comb begin
        rd_mux = '0;
        case (word_addr(s_axi_control.araddr))
            ADDR_CTRL:  rd_mux = DATA_W'({auto_restart, 3'b000, sts_ready, sts_idle, sts_done, k_ap_start});
            ADDR_GIE:   rd_mux = DATA_W'(gie);
            ADDR_IER:   rd_mux = DATA_W'(ier);
            ADDR_ISR:   rd_mux = DATA_W'(isr);
            ADDR_N_LO:  rd_mux = n_lo;
            ADDR_N_HI:  rd_mux = n_hi;
            ADDR_BEATS: rd_mux = beats;
            default:    rd_mux = '0;
        endcase
    end

    // ------------------------------------------------ registers and run
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            wr_addr             <= '0;
            gie                 <= 1'b0;
            ier                 <= 2'b00;
            isr                 <= 2'b00;
            n_lo                <= '0;
            n_hi                <= '0;
            beats               <= '0;
            auto_restart        <= 1'b0;
            sts_done            <= 1'b0;
            sts_ready           <= 1'b0;
            sts_idle            <= 1'b0;
            k_ap_start          <= 1'b0;
            k_n                 <= '0;
            interrupt           <= 1'b0;
            s_axi_control.rdata <= '0;
        end else begin
            if (aw_hs) wr_addr <= s_axi_control.awaddr;

            if (wr_gie && s_axi_control.wstrb[0]) gie          <= s_axi_control.wdata[0];
            if (wr_ier && s_axi_control.wstrb[0]) ier          <= s_axi_control.wdata[1:0];
            if (wr_ctrl && s_axi_control.wstrb[0]) auto_restart <= s_axi_control.wdata[7];
            if (wr_nlo) n_lo <= (n_lo & ~wmask) | (s_axi_control.wdata & wmask);
            if (wr_nhi) n_hi <= (n_hi & ~wmask) | (s_axi_control.wdata & wmask);

            isr <= isr_nxt;

            // Set beats clear-on-read when both land in the same cycle.
            sts_done  <= k_ap_done  | (sts_done  & ~ctrl_rd);
            sts_ready <= k_ap_ready | (sts_ready & ~ctrl_rd);
            sts_idle  <= k_ap_idle;

            if (start_req) begin
                k_ap_start <= 1'b1;
                k_n        <= {n_hi, n_lo};
            end else if (k_ap_start && k_ap_ready && !auto_restart) begin
                k_ap_start <= 1'b0;
            end

            if (start_req)                beats <= '0;
            else if (beat && beats != '1) beats <= beats + 32'd1;

            interrupt <= gie & (|(isr & ier));

            if (ar_hs) s_axi_control.rdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_stream_add_ctrl.sv
// Self-checking bench for stream_add_ctrl: reset values, register table,
// run sequencing, status/interrupt behaviour, randomized register and beat
// traffic against a word-level model, and reset during open transactions.
module tb_stream_add_ctrl;
    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        interrupt, k_ap_start;
    logic        k_ap_ready, k_ap_done, k_ap_idle;
    logic [63:0] k_n;
    logic        c_TVALID, c_TREADY, c_TLAST;

    stream_add_ctrl_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    stream_add_ctrl #(.ADDR_W(5), .DATA_W(32)) dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .s_axi_control (bus),
        .interrupt     (interrupt),
        .k_ap_start    (k_ap_start),
        .k_ap_ready    (k_ap_ready),
        .k_ap_done     (k_ap_done),
        .k_ap_idle     (k_ap_idle),
        .k_n           (k_n),
        .c_TVALID      (c_TVALID),
        .c_TREADY      (c_TREADY),
        .c_TLAST       (c_TLAST)
    );

    always #5 ap_clk = ~ap_clk;

    int vectors    = 0;
    int miscompares = 0;
    logic start_at_bvalid;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expired(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: handshake did not complete within bound", name);
    endtask

    task automatic tick();
        @(negedge ap_clk);
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input bit done_at_commit);
        int n;
        bus.awaddr = addr; bus.awvalid = 1'b1;
        bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
        n = 0;
        while (!bus.awready && n < 16) begin tick(); n++; end
        if (n == 16) expired("awready");
        tick();
        bus.awvalid = 1'b0;
        n = 0;
        while (!bus.wready && n < 16) begin tick(); n++; end
        if (n == 16) expired("wready");
        if (done_at_commit) k_ap_done = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        k_ap_done  = 1'b0;
        check("bvalid_latency", 64'(bus.bvalid), 64'd1);
        start_at_bvalid = k_ap_start;
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] addr, input bit done_at_ar, output logic [31:0] data);
        int n;
        bus.araddr = addr; bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready && n < 16) begin tick(); n++; end
        if (n == 16) expired("arready");
        if (done_at_ar) k_ap_done = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        k_ap_done   = 1'b0;
        check("rvalid_latency", 64'(bus.rvalid), 64'd1);
        data = bus.rdata;
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
    endtask

    task automatic pulse_ready();
        k_ap_ready = 1'b1; tick(); k_ap_ready = 1'b0;
    endtask

    task automatic pulse_done();
        k_ap_done = 1'b1; tick(); k_ap_done = 1'b0;
    endtask

    task automatic tap(input logic v, input logic r, input logic l);
        c_TVALID = v; c_TREADY = r; c_TLAST = l; tick();
        c_TVALID = 1'b0; c_TREADY = 1'b0; c_TLAST = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] mreg [8];
        logic [31:0] wmask [8];
        int          sel [6];
        logic [31:0] exp_hold;

        vecs[0]  = '{5'h10, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
        vecs[1]  = '{5'h10, 32'h11223344, 4'h5, 32'hDE22BE44};
        vecs[2]  = '{5'h14, 32'hCAFEF00D, 4'hA, 32'hCA00F000};
        vecs[3]  = '{5'h04, 32'hFFFFFFFF, 4'hF, 32'h00000001};
        vecs[4]  = '{5'h04, 32'h00000000, 4'hE, 32'h00000001};
        vecs[5]  = '{5'h04, 32'h00000000, 4'h1, 32'h00000000};
        vecs[6]  = '{5'h08, 32'h000000FF, 4'h1, 32'h00000003};
        vecs[7]  = '{5'h08, 32'h00000000, 4'h1, 32'h00000000};
        vecs[8]  = '{5'h18, 32'h00001234, 4'hF, 32'h00000000};
        vecs[9]  = '{5'h1C, 32'hFFFFFFFF, 4'hF, 32'h00000000};
        vecs[10] = '{5'h14, 32'h00000000, 4'hF, 32'h00000000};
        vecs[11] = '{5'h10, 32'h00000000, 4'hF, 32'h00000000};

        ap_rst_n = 1'b0;
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        k_ap_ready = 1'b0; k_ap_done = 1'b0; k_ap_idle = 1'b1;
        c_TVALID = 1'b0; c_TREADY = 1'b0; c_TLAST = 1'b0;
        start_at_bvalid = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_awready", 64'(bus.awready), 64'd1);
        check("rst_arready", 64'(bus.arready), 64'd1);
        check("rst_wready",  64'(bus.wready),  64'd0);
        check("rst_bvalid",  64'(bus.bvalid),  64'd0);
        check("rst_rvalid",  64'(bus.rvalid),  64'd0);
        check("rst_rdata",   64'(bus.rdata),   64'd0);
        check("rst_start",   64'(k_ap_start),  64'd0);
        check("rst_k_n",     k_n,              64'd0);
        check("rst_irq",     64'(interrupt),   64'd0);
        ap_rst_n = 1'b1;
        tick();
        check("arready_after_rst", 64'(bus.arready), 64'd1);
        tick();
        axi_read(5'h00, 1'b0, rd);
        check("ctrl_idle_only", 64'(rd), 64'h4);

        // Register table: write then read back
        for (int i = 0; i < 12; i++) begin
            axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 1'b0);
            axi_read(vecs[i].addr, 1'b0, rd);
            check($sformatf("table_%0d", i), 64'(rd), 64'(vecs[i].exp));
        end

        // Basic run
        axi_write(5'h10, 32'd5, 4'hF, 1'b0);
        axi_write(5'h14, 32'd0, 4'hF, 1'b0);
        axi_write(5'h00, 32'd1, 4'hF, 1'b0);
        check("start_at_bvalid", 64'(start_at_bvalid), 64'd1);
        check("k_n_latched", k_n, 64'd5);
        check("start_high", 64'(k_ap_start), 64'd1);
        pulse_ready();
        check("start_cleared_by_ready", 64'(k_ap_start), 64'd0);

        // Beat counting and clear-on-read
        tap(1, 1, 0); tap(1, 1, 0); tap(1, 1, 0);
        tap(1, 0, 0); tap(0, 1, 0);
        tap(1, 1, 0); tap(1, 1, 0); tap(1, 1, 1);
        pulse_done();
        axi_read(5'h00, 1'b0, rd);
        check("done_first_read", 64'(rd[1]), 64'd1);
        check("ready_first_read", 64'(rd[3]), 64'd1);
        axi_read(5'h00, 1'b0, rd);
        check("done_second_read", 64'(rd[1]), 64'd0);
        check("ready_second_read", 64'(rd[3]), 64'd0);
        axi_read(5'h18, 1'b0, rd);
        check("beats_count", 64'(rd), 64'd5);
        // Done event on the clear-on-read cycle: set wins
        axi_read(5'h00, 1'b1, rd);
        check("done_collide_rdata", 64'(rd[1]), 64'd0);
        axi_read(5'h00, 1'b0, rd);
        check("done_collide_kept", 64'(rd[1]), 64'd1);

        // Interrupt path
        axi_write(5'h08, 32'd1, 4'hF, 1'b0);
        pulse_done();
        tick();
        check("irq_gated_by_gie", 64'(interrupt), 64'd0);
        axi_write(5'h04, 32'd1, 4'hF, 1'b0);
        tick();
        check("irq_on_gie", 64'(interrupt), 64'd1);
        axi_write(5'h0C, 32'd1, 4'hF, 1'b0);
        check("irq_cleared", 64'(interrupt), 64'd0);
        pulse_done();
        tick();
        check("irq_on_done", 64'(interrupt), 64'd1);
        axi_write(5'h0C, 32'd1, 4'hF, 1'b1);
        axi_read(5'h0C, 1'b0, rd);
        check("isr_toggle_and_set", 64'(rd), 64'd1);
        axi_write(5'h0C, 32'd1, 4'hF, 1'b0);
        axi_read(5'h0C, 1'b0, rd);
        check("isr_toggle_clear", 64'(rd), 64'd0);
        axi_write(5'h0C, 32'd2, 4'hF, 1'b0);
        axi_read(5'h0C, 1'b0, rd);
        check("isr_toggle_set", 64'(rd), 64'd2);
        axi_write(5'h0C, 32'd2, 4'hF, 1'b0);
        axi_write(5'h04, 32'd0, 4'hF, 1'b0);
        axi_write(5'h08, 32'd0, 4'hF, 1'b0);

        // Auto restart
        axi_write(5'h00, 32'h81, 4'hF, 1'b0);
        check("auto_start_high", 64'(k_ap_start), 64'd1);
        axi_read(5'h00, 1'b0, rd);
        check("ctrl_auto_bits", 64'(rd & 32'h81), 64'h81);
        pulse_ready();
        check("auto_hold_1", 64'(k_ap_start), 64'd1);
        pulse_ready();
        check("auto_hold_2", 64'(k_ap_start), 64'd1);
        tap(1, 1, 0); tap(1, 1, 0);
        axi_write(5'h10, 32'd9, 4'hF, 1'b0);
        axi_write(5'h00, 32'h81, 4'hF, 1'b0);
        check("k_n_stable_in_run", k_n, 64'd5);
        axi_read(5'h18, 1'b0, rd);
        check("beats_not_cleared", 64'(rd), 64'd2);
        axi_write(5'h00, 32'h00, 4'hF, 1'b0);
        check("start_after_auto_off", 64'(k_ap_start), 64'd1);
        pulse_ready();
        check("start_drop_auto_off", 64'(k_ap_start), 64'd0);
        axi_write(5'h00, 32'h01, 4'hF, 1'b0);
        check("k_n_next_run", k_n, 64'd9);
        pulse_ready();
        check("start_drop_run2", 64'(k_ap_start), 64'd0);

        // Randomized traffic against a word-level register model
        sel = '{1, 2, 4, 5, 6, 7};
        for (int i = 0; i < 8; i++) begin mreg[i] = '0; wmask[i] = '0; end
        wmask[1] = 32'h1; wmask[2] = 32'h3; wmask[4] = '1; wmask[5] = '1;
        mreg[4] = 32'd9;
        for (int it = 0; it < 80; it++) begin
            int          op, idx, len;
            logic [31:0] d, bm;
            logic [3:0]  s;
            op  = $urandom_range(0, 2);
            idx = sel[$urandom_range(0, 5)];
            if (op == 0) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                bm = '0;
                for (int b = 0; b < 4; b++) if (s[b]) bm[b*8 +: 8] = 8'hFF;
                bm = bm & wmask[idx];
                mreg[idx] = (mreg[idx] & ~bm) | (d & bm);
                axi_write(5'(idx * 4), d, s, 1'b0);
            end else if (op == 1) begin
                axi_read(5'(idx * 4), 1'b0, rd);
                check($sformatf("rand_rd_%0h", idx * 4), 64'(rd), 64'(mreg[idx]));
            end else begin
                len = $urandom_range(1, 8);
                for (int k = 0; k < len; k++) begin
                    logic v, r, l;
                    v = 1'($urandom); r = 1'($urandom); l = 1'($urandom_range(0, 3) == 0);
                    if (v && r && !l) mreg[6] = mreg[6] + 1;
                    tap(v, r, l);
                end
            end
        end
        axi_write(5'h00, 32'h01, 4'hF, 1'b0);
        check("rand_k_n", k_n, {mreg[5], mreg[4]});
        pulse_ready();
        axi_read(5'h18, 1'b0, rd);
        check("beats_cleared_on_start", 64'(rd), 64'd0);

        // Unmapped read, held read data, reset during open transactions
        axi_read(5'h1C, 1'b0, rd);
        check("unmapped_read", 64'(rd), 64'd0);
        exp_hold = mreg[4];
        bus.araddr = 5'h10; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("rvalid_hold", 64'(bus.rvalid), 64'd1);
            check("rdata_hold", 64'(bus.rdata), 64'(exp_hold));
            tick();
        end
        bus.rready = 1'b1; tick(); bus.rready = 1'b0;
        check("rvalid_drop", 64'(bus.rvalid), 64'd0);

        bus.araddr = 5'h10; bus.arvalid = 1'b1;
        bus.awaddr = 5'h10; bus.awvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0; bus.awvalid = 1'b0;
        check("mid_rvalid", 64'(bus.rvalid), 64'd1);
        check("mid_wready", 64'(bus.wready), 64'd1);
        ap_rst_n = 1'b0;
        tick();
        check("abort_rvalid", 64'(bus.rvalid), 64'd0);
        check("abort_rdata", 64'(bus.rdata), 64'd0);
        check("abort_wready", 64'(bus.wready), 64'd0);
        check("abort_awready", 64'(bus.awready), 64'd1);
        check("abort_arready", 64'(bus.arready), 64'd1);
        check("abort_k_n", k_n, 64'd0);
        ap_rst_n = 1'b1;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/stream_add_ctrl.md
# stream_add_ctrl

AXI4-Lite control slave and run sequencer for the stream-add kernel. Holds the host-visible register map, drives the kernel `ap_start`/`ap_continue`-style handshake, latches `n` for the run, and monitors the output stream. Tracks completion and raises `interrupt`. Sits between the host control port `s_axi_control_*` and the `StreamAdd` kernel core inside the XRT wrapper.

## Interface
- `ADDR_W`, default 5: AXI-Lite address width.
- `DATA_W`, default 32: AXI-Lite data width; fixed at 32.
- `ap_clk`  in  1  clock; all logic on its rising edge.
- `ap_rst_n`  in  1  synchronous, active-low reset.
- `s_axi_control_AWADDR`/`AWVALID`/`AWREADY`  in/in/out  5/1/1  write address channel.
- `s_axi_control_WDATA`/`WSTRB`/`WVALID`/`WREADY`  in/in/in/out  32/4/1/1  write data channel.
- `s_axi_control_BRESP`/`BVALID`/`BREADY`  out/out/in  2/1/1  write response channel; BRESP is always 0.
- `s_axi_control_ARADDR`/`ARVALID`/`ARREADY`  in/in/out  5/1/1  read address channel.
- `s_axi_control_RDATA`/`RRESP`/`RVALID`/`RREADY`  out/out/out/in  32/2/1/1  read data channel; RRESP is always 0.
- `interrupt`  out  1  level interrupt to the host.
- `k_ap_start`  out  1  start request to the kernel.
- `k_ap_ready`/`k_ap_done`/`k_ap_idle`  in  1 each  kernel status pulses and level.
- `k_n`  out  64  element count, held stable for the whole run.
- `c_TVALID`/`c_TREADY`/`c_TLAST`  in  1 each  passive tap on the kernel output stream.

## Operation
- Register map, word addresses:
  - 0x00 CTRL: bit0 ap_start (R/W1S), bit1 ap_done (RO, clear-on-read), bit2 ap_idle (RO), bit3 ap_ready (RO, clear-on-read), bit7 auto_restart (R/W).
  - 0x04 GIE, bit0.
  - 0x08 IER: bit0 done, bit1 ready.
  - 0x0C ISR: bits1:0, toggle-on-write-1.
  - 0x10 N_LO.
  - 0x14 N_HI.
  - 0x18 BEATS (RO).
- Unmapped reads return 0. Unmapped writes complete with OKAY and have no effect.
- WSTRB is honoured per byte on all R/W registers.
- Write FSM:
  - WIDLE: AWREADY=1. On AW handshake, latch the address and go to WDATA.
  - WDATA: WREADY=1. On W handshake, commit the write and go to WRESP.
  - WRESP: BVALID=1. On BREADY, go to WIDLE.
- Read FSM:
  - RIDLE: ARREADY=1. On AR handshake, register RDATA and go to RDATA.
  - RDATA: RVALID=1. Hold RDATA until RREADY, then go to RIDLE.
- Run sequencing:
  - Writing CTRL bit0=1 while `k_ap_start`=0 sets `k_ap_start`, copies {N_HI,N_LO} into `k_n`, and clears BEATS.
  - `k_ap_start` stays high until a cycle with `k_ap_ready`=1. It then clears, unless auto_restart=1.
  - A start write while `k_ap_start`=1 is ignored.
- Status latches:
  - `k_ap_ready` sets ap_ready and ISR[1] (if IER[1]).
  - `k_ap_done` sets ap_done and ISR[0] (if IER[0]).
  - ap_idle mirrors `k_ap_idle` with a one-cycle register.
- BEATS: increments on `c_TVALID & c_TREADY & ~c_TLAST`, saturating at 0xFFFFFFFF. The TLAST close-token beat is not counted.
- `interrupt` = GIE & |(ISR & IER), registered.

## Timing
- Reset values:
  - AWREADY=1, ARREADY=1, WREADY=0, BVALID=0, RVALID=0, RDATA=0.
  - `k_ap_start`=0, `k_n`=0, interrupt=0.
  - All registers 0, except ap_idle, which follows the kernel after 1 cycle.
- Read latency: RVALID rises on the cycle after the AR handshake.
- Write latency:
  - WREADY rises on the cycle after the AW handshake.
  - BVALID rises on the cycle after the W handshake.
  - The written value is visible on the cycle BVALID rises.
- AW and W presented together take 3 cycles to BVALID.
- Clear-on-read of ap_done/ap_ready happens on the AR handshake cycle of address 0x00. If a set event occurs in the same cycle, set wins and the bit remains 1.
- `k_ap_start` rises on the cycle after the CTRL write commit.
- Writing ISR in the same cycle as a set event: result = old ^ wdata, then OR set.
- A reset asserted mid-transaction returns both FSMs to idle and aborts any pending B/R response. The next cycle shows reset values.
- Writes to N_LO/N_HI during a run do not change `k_n` until the next start.

## Test plan
- Reset, then read 0x00 with `k_ap_idle`=1 -> RDATA=0x4. ARREADY is 1 immediately after reset.
- Write 0x10=5, 0x14=0, 0x00=1 -> `k_n`=5 and `k_ap_start`=1. Pulse `k_ap_ready` -> `k_ap_start`=0 the next cycle.
- Tap 5 data beats plus 1 TLAST beat, then pulse `k_ap_done`:
  - First read of 0x00 -> bit1=1.
  - Second read -> bit1=0.
  - Read 0x18 -> 5.
- GIE=1, IER=1, then pulse done -> interrupt=1. Write ISR=1 -> interrupt=0 two cycles later.
- auto_restart=1 with start -> `k_ap_start` stays 1 across `k_ap_ready` pulses. Clearing bit7 -> start drops at the next ready.
- Read 0x1C -> 0. Hold RREADY=0 for 4 cycles -> RVALID and RDATA held. Assert reset mid-read -> RVALID=0 the next cycle.
